// File: rtl/reg_vec_sum_ctrl.sv
// Load/sum sequencer: captures N words into a register vector, then accumulates them
// through one shared adder (one element per cycle) and offers the total on a valid/ready port.
module reg_vec_sum_ctrl #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_start,
  output logic         io_busy,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [W-1:0] io_in_bits,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [W-1:0] io_out_bits
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSum, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    vec_q [N];
  logic            vec_we;
  logic            accept;

  // Moore outputs decoded from the registered state only
  always_comb begin
    io_busy      = (state_q != StIdle);
    io_in_ready  = (state_q == StLoad);
    io_out_valid = (state_q == StDone);
    io_out_bits  = (state_q == StDone) ? acc_q : '0;
  end

  assign accept = io_in_valid & io_in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    vec_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (io_start) begin
          state_d = StLoad;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          vec_we = 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StSum;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StSum: begin
        acc_d = acc_q + vec_q[idx_q];
        if (idx_q == IdxLast) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        // io_start is deliberately not looked at here; a new job must begin from idle
        if (io_out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < int'(N); i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      if (vec_we) begin
        vec_q[idx_q] <= io_in_bits;
      end
    end
  end

endmodule

// File: tb/tb_reg_vec_sum_ctrl.sv
// Directed bench for reg_vec_sum_ctrl: reset, back-to-back and bubbled loads, wrap-around,
// output back-pressure with ignored start, and mid-job reset abort.
module tb_reg_vec_sum_ctrl;

  localparam int unsigned N = 6;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_start;
  logic         io_busy;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [W-1:0] io_in_bits;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_out_bits;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] words [N];

  always #5 clk = ~clk;

  reg_vec_sum_ctrl #(.N(N), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_start     (io_start),
    .io_busy      (io_busy),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({io_busy, io_in_ready, io_out_valid} !== 3'b000 || io_out_bits !== '0) begin
      failures++;
      $display("FAIL %s: busy/in_ready/out_valid=%b%b%b bits=%h, required 000 bits=0",
               name, io_busy, io_in_ready, io_out_valid, io_out_bits);
    end
  endtask

  task automatic do_start(input string name);
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    checks++;
    if (io_busy !== 1'b1 || io_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_start: busy=%b in_ready=%b, required 1 1", name, io_busy, io_in_ready);
    end
  endtask

  // Feeds `count` entries of words[]; optional idle cycle before each word
  task automatic feed(input string name, input int count, input bit bubbles);
    for (int i = 0; i < count; i++) begin
      if (bubbles) begin
        io_in_valid = 1'b0;
        tick();
        checks++;
        if (io_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s_bubble_ready: in_ready=%b, required 1", name, io_in_ready);
        end
      end
      io_in_valid = 1'b1;
      io_in_bits  = words[i];
      tick();
    end
    io_in_valid = 1'b0;
    io_in_bits  = '0;
  endtask

  // Full job: start, load all words, wait for result, check latency/value/return to idle
  task automatic run_job(input string name, input bit bubbles, input logic [W-1:0] expected);
    int edges;
    io_out_ready = 1'b1;
    do_start(name);
    feed(name, N, bubbles);
    edges = 0;
    while (io_out_valid !== 1'b1 && edges < 40) begin
      checks++;
      if (io_in_ready !== 1'b0 || io_out_bits !== '0) begin
        failures++;
        $display("FAIL %s_sum_phase: in_ready=%b bits=%h, required 0 0",
                 name, io_in_ready, io_out_bits);
      end
      tick();
      edges++;
    end
    checks++;
    if (edges !== N) begin
      failures++;
      $display("FAIL %s_latency: edges=%0d, required %0d", name, edges, N);
    end
    checks++;
    if (io_out_bits !== expected || io_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_result: bits=%h busy=%b, required %h 1", name, io_out_bits, io_busy,
               expected);
    end
    tick();
    check_idle_outputs({name, "_idle"});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();
    check_idle_outputs("reset_release");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < int'(N); i++) words[i] = W'(i);
    run_job("b2b", 1'b0, 32'd15);
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < int'(N); i++) words[i] = W'(i);
    run_job("bubble", 1'b1, 32'd15);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < int'(N); i++) words[i] = 32'hFFFF_FFFF;
    run_job("wrap", 1'b0, 32'hFFFF_FFFA);
  endtask

  task automatic test_backpressure();
    int edges;
    words[0] = 32'd10; words[1] = 32'd20; words[2] = 32'd30;
    words[3] = 32'd40; words[4] = 32'd50; words[5] = 32'd60;
    io_out_ready = 1'b0;
    do_start("bp");
    feed("bp", N, 1'b0);
    edges = 0;
    while (io_out_valid !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    for (int c = 0; c < 10; c++) begin
      io_start = c[0];
      checks++;
      if (io_out_valid !== 1'b1 || io_out_bits !== 32'd210) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b bits=%h, required 1 000000d2", c, io_out_valid,
                 io_out_bits);
      end
      tick();
    end
    // Handshake with start asserted in the same cycle: start must be ignored
    io_start     = 1'b1;
    io_out_ready = 1'b1;
    tick();
    io_start = 1'b0;
    check_idle_outputs("bp_release");
    tick();
    check_idle_outputs("bp_no_restart");
  endtask

  task automatic test_abort();
    words[0] = 32'd100; words[1] = 32'd200; words[2] = 32'd300;
    io_out_ready = 1'b1;
    do_start("abort");
    feed("abort", 3, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("abort_reset");
    for (int i = 0; i < int'(N); i++) words[i] = W'(i + 1);
    run_job("after_abort", 1'b0, 32'd21);
  endtask

  initial begin
    reset        = 1'b1;
    io_start     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_wrap();
    test_backpressure();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
